// File: rtl/dot_product_stream_engine.sv
// Streaming fixed-point dot-product / squared-norm engine: per-lane multiply,
// adder tree and accumulator pipeline feeding a saturating Q-format result.

module dps_lane #(
    parameter int EW = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en_i,
    input  logic                   mask_i,
    input  logic [EW-1:0]          a_i,
    input  logic [EW-1:0]          b_i,
    output logic signed [2*EW-1:0] prod_o
);
    logic signed [2*EW-1:0] a_x, b_x, prod_d, prod_q;

    // Operands are widened first so the product is exact in 2*EW bits.
    always_comb begin
        a_x    = mask_i ? '0 : {{EW{a_i[EW-1]}}, a_i};
        b_x    = mask_i ? '0 : {{EW{b_i[EW-1]}}, b_i};
        prod_d = a_x * b_x;
    end

    always_ff @(posedge clk) begin
        if (!reset)    prod_q <= '0;
        else if (en_i) prod_q <= prod_d;
    end

    assign prod_o = prod_q;
endmodule

module dot_product_stream_engine #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int NO_OF_UNITS   = 8,
    parameter int NOE           = 16,
    parameter int FRAC_BITS     = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  mode,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]  vector1,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]  vector2,
    output logic [ELEMENT_WIDTH-1:0]              result,
    output logic                                  result_valid,
    input  logic                                  result_ready,
    output logic                                  overflow,
    output logic                                  busy
);
    localparam int EW         = ELEMENT_WIDTH;
    localparam int NU         = NO_OF_UNITS;
    localparam int BEATS      = (NOE + NU - 1) / NU;
    localparam int ACC_WIDTH  = 2*EW + $clog2(BEATS*NU) + 1;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TAIL_LANES = NOE - (BEATS-1)*NU;
    localparam int STAGES     = 2;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    typedef struct packed {
        logic          ovf;
        logic [EW-1:0] value;
    } res_t;

    state_t                      state_q, state_d;
    logic                        mode_q;
    logic [CNT_W-1:0]            beat_cnt_q, beat_cnt_d;
    logic [STAGES:0]             vld_pipe_q;
    logic signed [ACC_WIDTH-1:0] sum_d, sum_q, acc_d, acc_q, acc_shift;
    logic [ACC_WIDTH-EW:0]       hi;
    res_t                        res_d, res_q;
    logic                        go, accept, last_beat, drain_done;

    logic [NU-1:0][EW-1:0]   v1_lanes, v2_lanes, b_lanes;
    logic [NU-1:0][2*EW-1:0] prod;

    assign v1_lanes = vector1;
    assign v2_lanes = vector2;
    assign b_lanes  = mode_q ? v1_lanes : v2_lanes;

    assign go         = (state_q == IDLE) && start;
    assign accept     = (state_q == LOAD) && in_valid;
    assign last_beat  = (beat_cnt_q == CNT_W'(BEATS-1));
    assign drain_done = ~|vld_pipe_q;

    // Lanes past NOE on the final beat are zeroed before the multiplier.
    for (genvar k = 0; k < NU; k++) begin : g_lane
        localparam bit PAD = (k >= TAIL_LANES);
        dps_lane #(.EW(EW)) u_lane (
            .clk    (clk),
            .reset  (reset),
            .en_i   (accept),
            .mask_i (last_beat && PAD),
            .a_i    (v1_lanes[k]),
            .b_i    (b_lanes[k]),
            .prod_o (prod[k])
        );
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NU; k++)
            sum_d = sum_d + ACC_WIDTH'($signed(prod[k]));
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (go)
            beat_cnt_d = '0;
        else if (accept)
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
    end

    always_comb begin
        acc_d = acc_q;
        if (go)
            acc_d = '0;
        else if (vld_pipe_q[1])
            acc_d = acc_q + sum_q;
    end

    // Arithmetic shift floors toward -inf; clamp when the integer part
    // does not fit in EW bits (upper bits are not a pure sign extension).
    always_comb begin
        acc_shift   = acc_q >>> FRAC_BITS;
        hi          = acc_shift[ACC_WIDTH-1:EW-1];
        res_d.ovf   = 1'b0;
        res_d.value = acc_shift[EW-1:0];
        if (!((&hi) || (~|hi))) begin
            res_d.ovf   = 1'b1;
            res_d.value = hi[ACC_WIDTH-EW] ? {1'b1, {(EW-1){1'b0}}}
                                           : {1'b0, {(EW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q     <= 1'b0;
            beat_cnt_q <= '0;
            vld_pipe_q <= '0;
            sum_q      <= '0;
            acc_q      <= '0;
            res_q      <= '0;
        end else begin
            if (go)
                mode_q <= mode;
            beat_cnt_q <= beat_cnt_d;
            vld_pipe_q <= {vld_pipe_q[STAGES-1:0], accept};
            if (vld_pipe_q[0])
                sum_q <= sum_d;
            acc_q <= acc_d;
            if ((state_q == DRAIN) && drain_done)
                res_q <= res_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start)                state_d = LOAD;
            LOAD:  if (accept && last_beat)  state_d = DRAIN;
            DRAIN: if (drain_done)           state_d = DONE;
            DONE:  if (result_ready)         state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready     = (state_q == LOAD);
        result_valid = (state_q == DONE);
        busy         = (state_q != IDLE);
        result       = res_q.value;
        overflow     = res_q.ovf;
    end
endmodule
